// File: rtl/recovery_ctrl_if.sv
// ============================================================================
// Module      : recovery_ctrl_if
// Description : Handshake bundle between the recovery controller and the
//               redundant-core cluster (voter error flags, halt handshake,
//               register replay strobes and status).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface recovery_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_CORES  = 3
);
    logic [NUM_CORES-1:0]  error_i;
    logic                  halted_i;
    logic                  halt_o;
    logic                  copy_en_o;
    logic [ADDR_WIDTH-1:0] replay_addr_o;
    logic                  shift_o;
    logic                  resume_o;
    logic [NUM_CORES-1:0]  faulty_core_o;
    logic                  busy_o;
    logic                  fatal_o;

    // Controller side
    modport master (
        input  error_i,
        input  halted_i,
        output halt_o,
        output copy_en_o,
        output replay_addr_o,
        output shift_o,
        output resume_o,
        output faulty_core_o,
        output busy_o,
        output fatal_o
    );

    // Core-cluster / voter side
    modport slave (
        output error_i,
        output halted_i,
        input  halt_o,
        input  copy_en_o,
        input  replay_addr_o,
        input  shift_o,
        input  resume_o,
        input  faulty_core_o,
        input  busy_o,
        input  fatal_o
    );
endinterface

`default_nettype wire

// File: rtl/recovery_ctrl.sv
// ============================================================================
// Module      : recovery_ctrl
// Description : Fault-recovery sequencer for a redundant core cluster. On a
//               voter mismatch it halts the cores, replays every architectural
//               register from a healthy core, strobes a PC shift and resumes.
//               Back-to-back recoveries inside a guard window are counted and
//               escalate to a sticky fatal state.
//               Optional feature: define RECOVERY_CTRL_TIMEOUT_EN to add a
//               halt-acknowledge timeout that escalates to fatal.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module recovery_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int NUM_CORES      = 3,
    parameter int MAX_RETRY      = 3,
    parameter int GUARD_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    recovery_ctrl_if.master bus
);

    localparam int NUM_REG  = 2 ** ADDR_WIDTH;
    localparam int RETRY_W  = $clog2(MAX_RETRY + 2);
    localparam int GUARD_W  = $clog2(GUARD_CYCLES + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REG - 1);
    localparam logic [RETRY_W-1:0]    RETRY_MAX  = RETRY_W'(MAX_RETRY);
    localparam logic [GUARD_W-1:0]    GUARD_LOAD = GUARD_W'(GUARD_CYCLES);

    // Reject configurations the sequencer cannot honour
    if (MAX_RETRY < 1 || GUARD_CYCLES < 1 || TIMEOUT_CYCLES < 1 || NUM_CORES < 2) begin : g_bad_param
        $error("recovery_ctrl: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HALT     = 3'd1,
        COPY_GPR = 3'd2,
        COPY_PC  = 3'd3,
        RESUME   = 3'd4,
        FATAL    = 3'd5
    } state_t;

    state_t                 state,     state_nxt;
    logic [ADDR_WIDTH-1:0]  addr_cnt,  addr_nxt;
    logic [GUARD_W-1:0]     guard_cnt, guard_nxt;
    logic [RETRY_W-1:0]     retry_cnt, retry_nxt;
    logic [NUM_CORES-1:0]   faulty,    faulty_nxt;
    logic [RETRY_W-1:0]     new_retry;

`ifdef RECOVERY_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]        to_cnt,    to_nxt;
`endif

    // State and counter registers; reset returns to a quiet IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            guard_cnt <= '0;
            retry_cnt <= '0;
            faulty    <= '0;
`ifdef RECOVERY_CTRL_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            state     <= state_nxt;
            addr_cnt  <= addr_nxt;
            guard_cnt <= guard_nxt;
            retry_cnt <= retry_nxt;
            faulty    <= faulty_nxt;
`ifdef RECOVERY_CTRL_TIMEOUT_EN
            to_cnt    <= to_nxt;
`endif
        end
    end

    // Next-state and counter update logic
    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr_cnt;
        guard_nxt  = guard_cnt;
        retry_nxt  = retry_cnt;
        faulty_nxt = faulty;
`ifdef RECOVERY_CTRL_TIMEOUT_EN
        to_nxt     = '0;
`endif
        // An error soon after the last resume counts as consecutive
        new_retry  = (guard_cnt != '0) ? retry_cnt + RETRY_W'(1) : RETRY_W'(1);

        case (state)
            IDLE: begin
                if (guard_cnt != '0) begin
                    guard_nxt = guard_cnt - GUARD_W'(1);
                end
                if (|bus.error_i) begin
                    faulty_nxt = bus.error_i;
                    retry_nxt  = new_retry;
                    // No healthy majority, or too many consecutive faults
                    if ((&bus.error_i) || (new_retry > RETRY_MAX)) begin
                        state_nxt = FATAL;
                    end else begin
                        state_nxt = HALT;
                    end
                end
            end

            HALT: begin
                faulty_nxt = faulty | bus.error_i;
                if (bus.halted_i) begin
                    state_nxt = COPY_GPR;
                    addr_nxt  = '0;
                end
`ifdef RECOVERY_CTRL_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    state_nxt = FATAL;
                end else begin
                    to_nxt = to_cnt + TO_W'(1);
                end
`endif
            end

            COPY_GPR: begin
                faulty_nxt = faulty | bus.error_i;
                if (addr_cnt == LAST_ADDR) begin
                    state_nxt = COPY_PC;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt  = addr_cnt + ADDR_WIDTH'(1);
                end
            end

            COPY_PC: begin
                faulty_nxt = faulty | bus.error_i;
                state_nxt  = RESUME;
            end

            RESUME: begin
                guard_nxt = GUARD_LOAD;
                state_nxt = IDLE;
            end

            FATAL: begin
                state_nxt = FATAL;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state, no input feed-through
    always_comb begin
        bus.halt_o        = (state == HALT) || (state == COPY_GPR) ||
                            (state == COPY_PC) || (state == FATAL);
        bus.copy_en_o     = (state == COPY_GPR);
        bus.replay_addr_o = (state == COPY_GPR) ? addr_cnt : '0;
        bus.shift_o       = (state == COPY_PC);
        bus.resume_o      = (state == RESUME);
        bus.faulty_core_o = faulty;
        bus.busy_o        = (state != IDLE);
        bus.fatal_o       = (state == FATAL);
    end

endmodule

`default_nettype wire

// File: tb/tb_recovery_ctrl.sv
// ============================================================================
// Module      : tb_recovery_ctrl
// Description : Directed self-checking bench for recovery_ctrl.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_recovery_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    recovery_ctrl_if #(.ADDR_WIDTH(5), .NUM_CORES(3)) bus ();

    recovery_ctrl #(
        .ADDR_WIDTH    (5),
        .NUM_CORES     (3),
        .MAX_RETRY     (3),
        .GUARD_CYCLES  (16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case a sequence never completes
    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish (actual running, required finished)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.error_i  = '0;
        bus.halted_i = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".halt"},   bus.halt_o,        0);
        check({tag, ".copy"},   bus.copy_en_o,     0);
        check({tag, ".addr"},   bus.replay_addr_o, 0);
        check({tag, ".shift"},  bus.shift_o,       0);
        check({tag, ".resume"}, bus.resume_o,      0);
        check({tag, ".faulty"}, bus.faulty_core_o, 0);
        check({tag, ".busy"},   bus.busy_o,        0);
        check({tag, ".fatal"},  bus.fatal_o,       0);
    endtask

    // Full recovery from IDLE; inj is pulsed once mid-copy. Returns during
    // the resume_o cycle.
    task automatic recover(input logic [2:0] err, input logic [2:0] inj, input logic [2:0] exp_faulty);
        bus.error_i = err;
        tick();
        bus.error_i = '0;
        check("rec.halt", bus.halt_o, 1);
        check("rec.fatal0", bus.fatal_o, 0);
        tick();
        check("rec.halt_wait", bus.halt_o, 1);
        check("rec.copy_wait", bus.copy_en_o, 0);
        bus.halted_i = 1'b1;
        tick();
        bus.halted_i = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("rec.copy_en", bus.copy_en_o, 1);
            check("rec.addr", bus.replay_addr_o, i);
            bus.error_i = (i == 5) ? inj : 3'b000;
            tick();
        end
        bus.error_i = '0;
        check("rec.shift", bus.shift_o, 1);
        check("rec.pc_halt", bus.halt_o, 1);
        check("rec.pc_copy", bus.copy_en_o, 0);
        check("rec.pc_addr", bus.replay_addr_o, 0);
        tick();
        check("rec.resume", bus.resume_o, 1);
        check("rec.res_halt", bus.halt_o, 0);
        check("rec.res_shift", bus.shift_o, 0);
        check("rec.faulty", bus.faulty_core_o, exp_faulty);
    endtask

    initial begin
        bus.error_i  = '0;
        bus.halted_i = 1'b0;

        // Reset state
        do_reset();
        check_quiet("reset");

        // Single recovery on core 1
        recover(3'b010, 3'b000, 3'b010);
        tick();
        check("single.idle_busy", bus.busy_o, 0);
        check("single.resume_off", bus.resume_o, 0);
        check("single.faulty", bus.faulty_core_o, 3'b010);
        check("single.fatal", bus.fatal_o, 0);

        // All cores disagree -> fatal, sticky until reset
        do_reset();
        bus.error_i = 3'b111;
        tick();
        bus.error_i = '0;
        check("allone.fatal", bus.fatal_o, 1);
        check("allone.halt", bus.halt_o, 1);
        check("allone.busy", bus.busy_o, 1);
        check("allone.copy", bus.copy_en_o, 0);
        check("allone.faulty", bus.faulty_core_o, 3'b111);
        bus.halted_i = 1'b1;
        repeat (10) tick();
        bus.halted_i = 1'b0;
        check("allone.sticky", bus.fatal_o, 1);
        check("allone.nocopy", bus.copy_en_o, 0);
        check("allone.noresume", bus.resume_o, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("fatal_rst");

        // Consecutive faults 5 cycles apart -> fourth is fatal
        do_reset();
        for (int k = 0; k < 3; k++) begin
            recover(3'b010, 3'b000, 3'b010);
            repeat (5) tick();
        end
        bus.error_i = 3'b010;
        tick();
        bus.error_i = '0;
        check("retry.fatal", bus.fatal_o, 1);
        check("retry.halt", bus.halt_o, 1);

        // Same pattern 20 cycles apart -> every fault recovers
        do_reset();
        for (int k = 0; k < 4; k++) begin
            recover(3'b010, 3'b000, 3'b010);
            repeat (20) tick();
            check("spaced.nofatal", bus.fatal_o, 0);
            check("spaced.idle", bus.busy_o, 0);
        end

        // Reset mid-copy, then a clean restart from address 0
        do_reset();
        bus.error_i = 3'b100;
        tick();
        bus.error_i = '0;
        tick();
        bus.halted_i = 1'b1;
        tick();
        bus.halted_i = 1'b0;
        repeat (10) tick();
        check("midrst.addr10", bus.replay_addr_o, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("midrst");
        recover(3'b001, 3'b000, 3'b001);
        tick();

        // Reset wins over a simultaneous error
        rst = 1'b1;
        bus.error_i = 3'b010;
        tick();
        rst = 1'b0;
        bus.error_i = '0;
        check("rstprio.busy", bus.busy_o, 0);
        check("rstprio.faulty", bus.faulty_core_o, 0);

        // Second error during copy accumulates, sequence unchanged
        do_reset();
        recover(3'b100, 3'b001, 3'b101);
        tick();
        check("accum.idle", bus.busy_o, 0);
        check("accum.faulty", bus.faulty_core_o, 3'b101);

        // Halt acknowledge never arrives
        do_reset();
        bus.error_i = 3'b001;
        tick();
        bus.error_i = '0;
        repeat (63) tick();
        check("timeout.pre", bus.fatal_o, 0);
        check("timeout.pre_halt", bus.halt_o, 1);
        tick();
`ifdef RECOVERY_CTRL_TIMEOUT_EN
        check("timeout.fatal", bus.fatal_o, 1);
`else
        check("timeout.nofatal", bus.fatal_o, 0);
        repeat (40) tick();
        check("timeout.still_halt", bus.halt_o, 1);
        check("timeout.still_nofatal", bus.fatal_o, 0);
`endif
        do_reset();
        check_quiet("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
